// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: owner-state encoding, client ids and tag type shared by the arbiter
package mem_port_arbiter_pkg;
    localparam logic [1:0] ARB_IDLE = 2'b00;
    localparam logic [1:0] OWN_I = 2'b01;
    localparam logic [1:0] OWN_D = 2'b10;
    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;
    localparam int MEM_LAT_DEF = 4;
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: client fill handshakes plus the shared memory port
interface mem_port_arbiter_if;
    logic i_busy, d_busy;
    logic i_read_req, d_read_req;
    logic i_fill_done, d_fill_done;
    logic [15:0] i_addr, d_addr;
    logic d_wrt_mem;
    logic [15:0] d_wdata;
    logic i_pause, d_pause;
    logic d_wr_stall;
    logic i_data_valid, d_data_valid;
    logic mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic mem_data_valid;
    modport master (
        output i_busy, d_busy, i_read_req, d_read_req, i_fill_done, d_fill_done,
        output i_addr, d_addr, d_wrt_mem, d_wdata, mem_data_valid,
        input i_pause, d_pause, d_wr_stall, i_data_valid, d_data_valid,
        input mem_enable, mem_wr, mem_addr, mem_wdata
    );
    modport slave (
        input i_busy, d_busy, i_read_req, d_read_req, i_fill_done, d_fill_done,
        input i_addr, d_addr, d_wrt_mem, d_wdata, mem_data_valid,
        output i_pause, d_pause, d_wr_stall, i_data_valid, d_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_inflight_tag_pipe.sv
// inflight_tag_pipe: MEM_LAT-deep {valid,id} shift register aligning read returns with their issuer
module inflight_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  tag_t push,
    output tag_t tail
);
    tag_t pipe [MEM_LAT];
    always_ff @(posedge clk)
        if (!rst) pipe <= '{default: '0};
        else begin
            pipe[0] <= push;
            for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
        end
    assign tail = pipe[MEM_LAT-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the memory port to one cache fill at a time and routes read returns
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    logic [1:0] state, next_state;
    logic last_grant, grant_i, grant_d;
    logic rd_i, rd_d, wr;
    tag_t push, tail;
    always_comb begin
        grant_i = bus.i_busy & (~bus.d_busy | (last_grant == ID_D));
        grant_d = bus.d_busy & (~bus.i_busy | (last_grant == ID_I));
        next_state = state == ARB_IDLE ? (grant_i ? OWN_I : grant_d ? OWN_D : ARB_IDLE)
                   : state == OWN_I    ? (bus.i_fill_done ? ARB_IDLE : OWN_I)
                   : state == OWN_D    ? (bus.d_fill_done ? ARB_IDLE : OWN_D)
                   : ARB_IDLE;
    end
    always_ff @(posedge clk)
        if (!rst) begin
            state <= ARB_IDLE;
            last_grant <= ID_D;
        end else begin
            state <= next_state;
            if (state == ARB_IDLE && (grant_i || grant_d)) last_grant <= grant_i ? ID_I : ID_D;
        end
    // nothing issues or is routed while reset is held, so the port stays quiet from the first reset cycle
    assign rd_i = rst & (state == OWN_I) & bus.i_read_req;
    assign rd_d = rst & (state == OWN_D) & bus.d_read_req;
    assign wr = rst & (state == ARB_IDLE) & bus.d_wrt_mem;
    assign bus.mem_enable = rd_i | rd_d | wr;
    assign bus.mem_wr = wr;
    assign bus.mem_addr = rd_i ? bus.i_addr : (rd_d | wr) ? bus.d_addr : '0;
    assign bus.mem_wdata = wr ? bus.d_wdata : '0;
    assign bus.d_wr_stall = rst & bus.d_wrt_mem & (state != ARB_IDLE);
    assign bus.i_pause = state != OWN_I;
    assign bus.d_pause = state != OWN_D;
    assign push = '{valid: rd_i | rd_d, id: rd_d ? ID_D : ID_I};
    inflight_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tags (
        .clk (clk),
        .rst (rst),
        .push(push),
        .tail(tail)
    );
    assign bus.i_data_valid = rst & bus.mem_data_valid & tail.valid & (tail.id == ID_I);
    assign bus.d_data_valid = rst & bus.mem_data_valid & tail.valid & (tail.id == ID_D);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, read routing, write-through and reset flush
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
    logic clk, rst;
    int vectors, miscompares;
    mem_port_arbiter_if b ();
    mem_port_arbiter #(.MEM_LAT(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask
    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    // owner already granted; 8 reads, memory returns 4 cycles later, fill_done once the last return is in
    task automatic fill(input logic who, input logic [15:0] base, input logic stray);
        logic rd, ret;
        logic [15:0] a;
        for (int k = 0; k < 13; k++) begin
            rd = k < 8;
            ret = k >= 4 && k < 12;
            a = base + 16'(2 * k);
            if (who == ID_I) begin
                b.i_read_req = rd; b.i_addr = a; b.i_fill_done = k == 12;
            end else begin
                b.d_read_req = rd; b.d_addr = a; b.d_fill_done = k == 12;
            end
            if (stray) begin
                b.d_read_req = 1; b.d_addr = 16'hDEAD; b.d_wrt_mem = k == 2; b.d_wdata = 16'h5555;
            end
            b.mem_data_valid = ret;
            #1;
            chk1("owner_pause", who == ID_I ? b.i_pause : b.d_pause, 1'b0);
            chk1("loser_pause", who == ID_I ? b.d_pause : b.i_pause, 1'b1);
            chk1("rd_enable", b.mem_enable, rd);
            chk1("rd_wr", b.mem_wr, 1'b0);
            chk16("rd_addr", b.mem_addr, rd ? a : 16'h0000);
            chk16("rd_wdata", b.mem_wdata, 16'h0000);
            chk1("owner_dv", who == ID_I ? b.i_data_valid : b.d_data_valid, ret);
            chk1("loser_dv", who == ID_I ? b.d_data_valid : b.i_data_valid, 1'b0);
            if (stray && k == 2) chk1("wr_stall", b.d_wr_stall, 1'b1);
            tick;
        end
        b.i_read_req = 0; b.d_read_req = 0; b.i_fill_done = 0; b.d_fill_done = 0;
        b.d_wrt_mem = 0; b.mem_data_valid = 0;
    endtask
    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 0;
        b.i_busy = 0; b.d_busy = 0; b.i_read_req = 0; b.d_read_req = 0;
        b.i_fill_done = 0; b.d_fill_done = 0; b.i_addr = 0; b.d_addr = 0;
        b.d_wrt_mem = 0; b.d_wdata = 0; b.mem_data_valid = 0;
        tick;
        tick;
        b.mem_data_valid = 1;
        #1;
        chk1("rst_i_pause", b.i_pause, 1'b1);
        chk1("rst_d_pause", b.d_pause, 1'b1);
        chk1("rst_stall", b.d_wr_stall, 1'b0);
        chk1("rst_enable", b.mem_enable, 1'b0);
        chk1("rst_wr", b.mem_wr, 1'b0);
        chk1("rst_i_dv", b.i_data_valid, 1'b0);
        chk1("rst_d_dv", b.d_data_valid, 1'b0);
        b.mem_data_valid = 0;
        rst = 1;
        tick;
        b.i_busy = 1; b.d_busy = 1;
        #1;
        chk1("tie_i_pause", b.i_pause, 1'b1);
        chk1("tie_d_pause", b.d_pause, 1'b1);
        chk1("tie_enable", b.mem_enable, 1'b0);
        tick;
        fill(ID_I, 16'h0100, 1'b1);
        b.i_busy = 0;
        #1;
        chk1("rel_i_pause", b.i_pause, 1'b1);
        chk1("rel_d_pause", b.d_pause, 1'b1);
        chk1("rel_enable", b.mem_enable, 1'b0);
        tick;
        fill(ID_D, 16'h0200, 1'b0);
        b.i_busy = 1;
        #1;
        chk1("tie2_i_pause", b.i_pause, 1'b1);
        tick;
        fill(ID_I, 16'h0300, 1'b0);
        b.i_busy = 0; b.d_busy = 0;
        tick;
        b.i_busy = 1; b.d_wrt_mem = 1; b.d_addr = 16'h1234; b.d_wdata = 16'hBEEF;
        #1;
        chk1("wt_enable", b.mem_enable, 1'b1);
        chk1("wt_wr", b.mem_wr, 1'b1);
        chk16("wt_addr", b.mem_addr, 16'h1234);
        chk16("wt_wdata", b.mem_wdata, 16'hBEEF);
        chk1("wt_stall", b.d_wr_stall, 1'b0);
        tick;
        b.d_wrt_mem = 0;
        for (int k = 0; k < 3; k++) begin
            b.i_read_req = 1; b.i_addr = 16'h0400 + 16'(2 * k);
            if (k == 2) rst = 0;
            #1;
            if (k < 2) begin
                chk1("mid_i_pause", b.i_pause, 1'b0);
                chk1("mid_enable", b.mem_enable, 1'b1);
                chk16("mid_addr", b.mem_addr, 16'h0400 + 16'(2 * k));
            end
            tick;
        end
        b.i_busy = 0; b.i_read_req = 0; b.i_addr = 0; b.d_addr = 0; b.d_wdata = 0;
        for (int j = 0; j < 6; j++) begin
            b.mem_data_valid = 1;
            rst = j >= 2;
            #1;
            chk1("flush_i_dv", b.i_data_valid, 1'b0);
            chk1("flush_d_dv", b.d_data_valid, 1'b0);
            chk1("flush_i_pause", b.i_pause, 1'b1);
            chk1("flush_d_pause", b.d_pause, 1'b1);
            chk1("flush_enable", b.mem_enable, 1'b0);
            chk1("flush_stall", b.d_wr_stall, 1'b0);
            tick;
        end
        b.mem_data_valid = 0;
        b.d_wrt_mem = 1; b.d_addr = 16'h00A0; b.d_wdata = 16'h0F0F;
        #1;
        chk1("wt2_wr", b.mem_wr, 1'b1);
        chk16("wt2_addr", b.mem_addr, 16'h00A0);
        chk16("wt2_wdata", b.mem_wdata, 16'h0F0F);
        tick;
        b.d_wrt_mem = 0;
        #1;
        chk1("idle_enable", b.mem_enable, 1'b0);
        chk1("idle_wr", b.mem_wr, 1'b0);
        chk16("idle_addr", b.mem_addr, 16'h0000);
        chk16("idle_wdata", b.mem_wdata, 16'h0000);
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
